// File: rtl/match_controller_pkg.sv
// Shared match states, 7-segment codes and digit-enable patterns for the ping-pong match controller.
// Constants only: no latency, no backpressure.
package pp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SERVE     = 3'd1,
      ST_RALLY     = 3'd2,
      ST_POINT     = 3'd3,
      ST_GAME_OVER = 3'd4
   } state_t;

   // Segment order is {a,b,c,d,e,f,g}, active-low
   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] EN_P1  = 4'b0111;
   localparam logic [3:0] EN_P2  = 4'b1110;
   localparam logic [3:0] EN_OFF = 4'b1111;

endpackage

// File: rtl/match_controller_seg7_decode.sv
// Binary digit to active-low 7-segment pattern; values above 9 are blanked.
// Latency: combinational. Backpressure: none.
module seg7_decode
   import pp_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/match_controller.sv
// Ping-pong match sequencer: serve/rally/point/game-over FSM, scores, and a 2-digit scanned score display.
// Latency: all outputs registered, one cycle after the qualifying input. Backpressure: none; start=0 pauses play.
module match_controller
   import pp_pkg::*;
#(
   parameter int WIN_SCORE   = 9,
   parameter int SERVE_TICKS = 8,
   parameter int BLINK_TICKS = 4
) (
   input  logic       clkouts,
   input  logic       resetb,
   input  logic       start,
   input  logic       tick,
   input  logic       point1,
   input  logic       point2,
   output logic       run,
   output logic       ball_reset,
   output logic       serve_dir,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic [1:0] winner,
   output logic [2:0] state_dbg,
   output logic [6:0] outs,
   output logic [3:0] en
);

   localparam logic [15:0] SERVE_LOAD = 16'(SERVE_TICKS);
   localparam logic [15:0] BLINK_LAST = 16'(BLINK_TICKS - 1);
   localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

   state_t      state;
   logic        start_q;
   logic        start_rise;
   logic [15:0] serve_cnt;
   logic [15:0] blink_cnt;
   logic        blink_phase;
   logic [3:0]  score1_inc;
   logic [3:0]  score2_inc;
   logic        scan_sel;
   logic [3:0]  scan_digit;
   logic [6:0]  scan_seg;
   logic        scan_blank;

   assign start_rise = start & ~start_q;
   assign state_dbg  = state;

   // Saturating increments keep scores inside the displayable 0..9 range
   always_comb begin
      score1_inc = (score1 >= 4'd9) ? 4'd9 : score1 + 4'd1;
      score2_inc = (score2 >= 4'd9) ? 4'd9 : score2 + 4'd1;
   end

   always_ff @(posedge clkouts) begin
      if (!resetb) begin
         state       <= ST_IDLE;
         start_q     <= 1'b0;
         run         <= 1'b0;
         ball_reset  <= 1'b0;
         serve_dir   <= 1'b0;
         score1      <= 4'd0;
         score2      <= 4'd0;
         winner      <= 2'b00;
         serve_cnt   <= 16'd0;
         blink_cnt   <= 16'd0;
         blink_phase <= 1'b0;
      end else begin
         start_q    <= start;
         ball_reset <= 1'b0;
         run        <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_rise) begin
                  state      <= ST_SERVE;
                  serve_dir  <= 1'b0;
                  ball_reset <= 1'b1;
                  serve_cnt  <= SERVE_LOAD;
               end
            end
            ST_SERVE: begin
               if (start && tick) begin
                  if (serve_cnt <= 16'd1) begin
                     serve_cnt <= 16'd0;
                     state     <= ST_RALLY;
                     run       <= 1'b1;
                  end else begin
                     serve_cnt <= serve_cnt - 16'd1;
                  end
               end
            end
            ST_RALLY: begin
               if (start) begin
                  run <= 1'b1;
                  if (point1 && point2) begin
                     run        <= 1'b0;
                     state      <= ST_POINT;
                     ball_reset <= 1'b1;
                  end else if (point1) begin
                     run       <= 1'b0;
                     score1    <= score1_inc;
                     serve_dir <= 1'b0;
                     if (score1_inc == WIN) begin
                        state       <= ST_GAME_OVER;
                        winner      <= 2'b01;
                        blink_cnt   <= 16'd0;
                        blink_phase <= 1'b0;
                     end else begin
                        state      <= ST_POINT;
                        ball_reset <= 1'b1;
                     end
                  end else if (point2) begin
                     run       <= 1'b0;
                     score2    <= score2_inc;
                     serve_dir <= 1'b1;
                     if (score2_inc == WIN) begin
                        state       <= ST_GAME_OVER;
                        winner      <= 2'b10;
                        blink_cnt   <= 16'd0;
                        blink_phase <= 1'b0;
                     end else begin
                        state      <= ST_POINT;
                        ball_reset <= 1'b1;
                     end
                  end
               end
            end
            ST_POINT: begin
               state     <= ST_SERVE;
               serve_cnt <= SERVE_LOAD;
            end
            ST_GAME_OVER: begin
               if (start_rise) begin
                  state      <= ST_SERVE;
                  score1     <= 4'd0;
                  score2     <= 4'd0;
                  winner     <= 2'b00;
                  serve_dir  <= 1'b0;
                  ball_reset <= 1'b1;
                  serve_cnt  <= SERVE_LOAD;
               end else if (tick) begin
                  if (blink_cnt >= BLINK_LAST) begin
                     blink_cnt   <= 16'd0;
                     blink_phase <= ~blink_phase;
                  end else begin
                     blink_cnt <= blink_cnt + 16'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign scan_digit = scan_sel ? score2 : score1;
   assign scan_blank = (state == ST_GAME_OVER) && blink_phase &&
                       (scan_sel ? (winner == 2'b10) : (winner == 2'b01));

   seg7_decode u_seg7_decode (
      .digit (scan_digit),
      .seg   (scan_seg)
   );

   // scan_sel=0 drives player 1's digit, so the first post-reset cycle shows score1
   always_ff @(posedge clkouts) begin
      if (!resetb) begin
         scan_sel <= 1'b0;
         en       <= EN_OFF;
         outs     <= SEG_BLANK;
      end else begin
         scan_sel <= ~scan_sel;
         en       <= scan_sel ? EN_P2 : EN_P1;
         outs     <= scan_blank ? SEG_BLANK : scan_seg;
      end
   end

endmodule

// File: tb/tb_match_controller.sv
// Directed match walk-through with randomized tick spacing and point injection, checked against a rule-level model.
module tb_match_controller;
   import pp_pkg::*;

   localparam int WIN = 9;
   localparam int ST  = 8;
   localparam int BT  = 4;

   logic       clkouts = 1'b0;
   logic       resetb, start, tick, point1, point2;
   logic       run, ball_reset, serve_dir;
   logic [3:0] score1, score2, en;
   logic [1:0] winner;
   logic [2:0] state_dbg;
   logic [6:0] outs;

   always #5 clkouts = ~clkouts;

   match_controller #(.WIN_SCORE(WIN), .SERVE_TICKS(ST), .BLINK_TICKS(BT)) dut (
      .clkouts    (clkouts),
      .resetb     (resetb),
      .start      (start),
      .tick       (tick),
      .point1     (point1),
      .point2     (point2),
      .run        (run),
      .ball_reset (ball_reset),
      .serve_dir  (serve_dir),
      .score1     (score1),
      .score2     (score2),
      .winner     (winner),
      .state_dbg  (state_dbg),
      .outs       (outs),
      .en         (en)
   );

   int checks   = 0;
   int failures = 0;

   logic [6:0] segtab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   // Rule-level model: serve progress counted up, blink phase derived from total ticks in game over
   state_t     m_state;
   bit         m_run, m_br, m_dir, m_sq, m_idx, m_rise, m_blank;
   int         m_s1, m_s2, m_win, m_seen, m_bt, m_dv;
   logic [3:0] m_en;
   logic [6:0] m_outs;

   always @(posedge clkouts) begin
      if (!resetb) begin
         m_state = ST_IDLE; m_run = 0; m_br = 0; m_dir = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
         m_seen = 0; m_bt = 0; m_sq = 0; m_idx = 0; m_en = 4'b1111; m_outs = 7'b1111111;
      end else begin
         m_rise = start && !m_sq;
         m_sq   = start;
         m_dv    = m_idx ? m_s2 : m_s1;
         m_blank = (m_state == ST_GAME_OVER) && ((m_bt / BT) % 2 == 1) && (m_win == (m_idx ? 2 : 1));
         m_en    = m_idx ? 4'b1110 : 4'b0111;
         m_outs  = m_blank ? 7'b1111111 : segtab[m_dv];
         m_idx   = !m_idx;
         m_br = 0;
         case (m_state)
            ST_IDLE: if (m_rise) begin m_state = ST_SERVE; m_dir = 0; m_br = 1; m_seen = 0; end
            ST_SERVE: if (start && tick) begin
               m_seen++;
               if (m_seen == ST) m_state = ST_RALLY;
            end
            ST_RALLY: if (start) begin
               if (point1 && point2) begin
                  m_state = ST_POINT; m_br = 1;
               end else if (point1 || point2) begin
                  if (point1) begin m_s1 = (m_s1 + 1 > 9) ? 9 : m_s1 + 1; m_dir = 0; end
                  else        begin m_s2 = (m_s2 + 1 > 9) ? 9 : m_s2 + 1; m_dir = 1; end
                  if (m_s1 == WIN || m_s2 == WIN) begin
                     m_state = ST_GAME_OVER; m_win = (m_s1 == WIN) ? 1 : 2; m_bt = 0;
                  end else begin
                     m_state = ST_POINT; m_br = 1;
                  end
               end
            end
            ST_POINT: begin m_state = ST_SERVE; m_seen = 0; end
            ST_GAME_OVER: if (m_rise) begin
               m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; m_br = 1; m_state = ST_SERVE; m_seen = 0;
            end else if (tick) begin
               m_bt++;
            end
            default: m_state = ST_IDLE;
         endcase
         m_run = (m_state == ST_RALLY) && start;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clkouts);
      #1;
      chk("run", run, m_run);
      chk("ball_reset", ball_reset, m_br);
      chk("serve_dir", serve_dir, m_dir);
      chk("score1", score1, m_s1);
      chk("score2", score2, m_s2);
      chk("winner", winner, m_win);
      chk("state", state_dbg, m_state);
      chk("en", en, m_en);
      chk("outs", outs, m_outs);
   endtask

   task automatic do_tick(input int gap);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      repeat (gap) cyc();
   endtask

   task automatic serve_out();
      repeat (ST) do_tick($urandom_range(0, 2));
      chk("serve_done_state", state_dbg, ST_RALLY);
      chk("serve_done_run", run, 1);
   endtask

   task automatic pulse(input logic a, input logic b);
      point1 = a;
      point2 = b;
      cyc();
      point1 = 1'b0;
      point2 = 1'b0;
   endtask

   task automatic blink_chk(input logic ph);
      repeat (2) begin
         cyc();
         if (en === 4'b0111) chk("blink_p1", outs, ph ? 7'b1111111 : 7'b0000100);
         else                chk("digit_p2", outs, segtab[m_s2]);
      end
   endtask

   initial begin
      resetb = 1'b0; start = 1'b0; tick = 1'b0; point1 = 1'b0; point2 = 1'b0;
      repeat (3) cyc();
      chk("rst_en", en, 4'b1111);
      chk("rst_outs", outs, 7'b1111111);
      chk("rst_state", state_dbg, ST_IDLE);
      chk("rst_winner", winner, 2'b00);

      resetb = 1'b1;
      cyc();
      chk("scan0_en", en, 4'b0111);
      chk("scan0_outs", outs, 7'b0000001);
      cyc();
      chk("scan1_en", en, 4'b1110);
      chk("scan1_outs", outs, 7'b0000001);

      start = 1'b1;
      cyc();
      chk("start_br", ball_reset, 1);
      chk("start_state", state_dbg, ST_SERVE);
      cyc();
      chk("start_br_off", ball_reset, 0);
      repeat (ST - 1) do_tick($urandom_range(0, 3));
      chk("serve7_run", run, 0);
      chk("serve7_state", state_dbg, ST_SERVE);
      do_tick(0);
      chk("serve8_run", run, 1);
      chk("serve8_state", state_dbg, ST_RALLY);

      pulse(1'b0, 1'b1);
      chk("p2_score2", score2, 1);
      chk("p2_dir", serve_dir, 1);
      chk("p2_br", ball_reset, 1);
      chk("p2_state", state_dbg, ST_POINT);
      cyc();
      chk("p2_serve", state_dbg, ST_SERVE);
      chk("p2_br_off", ball_reset, 0);
      serve_out();

      pulse(1'b1, 1'b1);
      chk("let_s1", score1, 0);
      chk("let_s2", score2, 1);
      chk("let_dir", serve_dir, 1);
      chk("let_state", state_dbg, ST_POINT);
      cyc();
      chk("let_serve", state_dbg, ST_SERVE);

      // Pause mid-serve: ticks and points must have no effect, and re-raising start must not restart
      repeat (3) do_tick(0);
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick = 1'b1;
         point1 = 1'($urandom_range(0, 1));
         point2 = 1'($urandom_range(0, 1));
         cyc();
         tick = 1'b0; point1 = 1'b0; point2 = 1'b0;
         cyc();
      end
      chk("pause_state", state_dbg, ST_SERVE);
      chk("pause_run", run, 0);
      start = 1'b1;
      cyc();
      chk("unpause_state", state_dbg, ST_SERVE);
      chk("unpause_br", ball_reset, 0);
      repeat (ST - 4) do_tick(0);
      chk("resume_state", state_dbg, ST_SERVE);
      do_tick(0);
      chk("resume_rally", state_dbg, ST_RALLY);

      start = 1'b0;
      cyc();
      chk("rally_pause_run", run, 0);
      repeat (3) begin
         pulse(1'b1, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) cyc();
      end
      chk("rally_pause_s1", score1, 0);
      start = 1'b1;
      cyc();
      chk("rally_resume_state", state_dbg, ST_RALLY);
      chk("rally_resume_run", run, 1);
      chk("rally_resume_br", ball_reset, 0);

      repeat (4) begin
         repeat ($urandom_range(0, 3)) do_tick(0);
         if ($urandom_range(0, 1) == 0) pulse(1'b0, 1'b1);
         else                           pulse(1'b1, 1'b1);
         cyc();
         serve_out();
      end

      for (int i = 0; i < WIN; i++) begin
         repeat ($urandom_range(0, 2)) do_tick(0);
         pulse(1'b1, 1'b0);
         if (i < WIN - 1) begin
            cyc();
            serve_out();
         end
      end
      chk("win_winner", winner, 2'b01);
      chk("win_score1", score1, 9);
      chk("win_state", state_dbg, ST_GAME_OVER);
      chk("win_run", run, 0);
      chk("win_br", ball_reset, 0);

      blink_chk(1'b0);
      for (int g = 1; g <= 4; g++) begin
         repeat (BT) do_tick(0);
         blink_chk(1'(g % 2));
      end

      start = 1'b0;
      cyc();
      start = 1'b1;
      cyc();
      chk("restart_s1", score1, 0);
      chk("restart_s2", score2, 0);
      chk("restart_winner", winner, 2'b00);
      chk("restart_state", state_dbg, ST_SERVE);
      chk("restart_br", ball_reset, 1);
      cyc();
      serve_out();
      repeat (5) begin
         pulse(1'b1, 1'b0);
         cyc();
         serve_out();
      end
      chk("pre_rst_s1", score1, 5);

      resetb = 1'b0;
      cyc();
      chk("abort_state", state_dbg, ST_IDLE);
      chk("abort_s1", score1, 0);
      chk("abort_en", en, 4'b1111);
      chk("abort_outs", outs, 7'b1111111);
      chk("abort_run", run, 0);
      resetb = 1'b1;
      repeat (2) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/match_controller.md
# match_controller

Game-level sequencer for the 8x8 LED ping-pong design. Owns the match state (idle, serve countdown, rally, point handling, game over), keeps both players' scores, and gates the ball-motion engine through `run` / `ball_reset` / `serve_dir`. It also time-multiplexes the two score digits onto the 4-digit 7-segment display, blinking the winner's digit at game end.

## Interface
- `WIN_SCORE`, 9: points needed to win. Legal range is 1..9.
- `SERVE_TICKS`, 8: `tick` strobes spent in SERVE before the rally starts. Must be ≥1.
- `BLINK_TICKS`, 4: `tick` strobes per blink half-period in GAME_OVER. Must be ≥1.
- `clkouts` in 1: display/scan clock; all logic is on its rising edge.
- `resetb` in 1: synchronous, active-low reset.
- `start` in 1: level switch, already synchronised. Its rising edge starts or restarts a match. A low level pauses the match.
- `tick` in 1: one-cycle game-step strobe, aligned to ball moves.
- `point1` in 1: one-cycle pulse; player 1 scored (ball left the board at player 2's side).
- `point2` in 1: one-cycle pulse; player 2 scored.
- `run` out 1: ball engine may move the ball.
- `ball_reset` out 1: one-cycle pulse; engine recentres the ball.
- `serve_dir` out 1: 0 = serve toward player 2 (+x); 1 = serve toward player 1.
- `score1` out 4: player 1 score, binary 0..9.
- `score2` out 4: player 2 score, binary 0..9.
- `winner` out 2: 00 = none, 01 = player 1, 10 = player 2.
- `state_dbg` out 3: current state encoding.
- `outs` out 7: segment pattern, active-low.
- `en` out 4: digit enables, active-low.

## Operation
- States are IDLE, SERVE, RALLY, POINT, GAME_OVER. Start edge: `start_q` register; `start_rise = start & ~start_q`.
- IDLE:
  - Outputs: `run`=0, scores 0.
  - On `start_rise`: go to SERVE, set `serve_dir`=0, assert `ball_reset` for one cycle.
- SERVE:
  - `run`=0. A down-counter loads SERVE_TICKS on entry and decrements on `tick`.
  - When the counter reaches 0, go to RALLY.
- RALLY:
  - `run`=`start`.
  - `point1` alone: `score1`+1, `serve_dir`=0 (serve toward player 2, who conceded).
  - `point2` alone: `score2`+1, `serve_dir`=1.
  - After either, next state is POINT, or GAME_OVER if the new score equals WIN_SCORE. `winner` is set in the same cycle as the score update.
  - `point1` and `point2` together: a let. Neither score changes, `serve_dir` is unchanged, go to POINT.
- POINT: `ball_reset`=1 for exactly this one cycle, `run`=0, then go to SERVE.
- GAME_OVER:
  - `run`=0. Scores and `winner` are held.
  - Blink phase toggles every BLINK_TICKS ticks.
  - On `start_rise`: clear scores and `winner`, `serve_dir`=0, assert `ball_reset`, go to SERVE.
- Pause (`start`=0 in SERVE or RALLY):
  - `run`=0; the SERVE counter and blink counter freeze.
  - `point1`/`point2` are ignored; `start_rise` is ignored outside IDLE and GAME_OVER.
- Points seen in any state other than RALLY are ignored. Scores saturate at 9.
- Display scan:
  - Alternates every `clkouts` cycle: `en`=4'b0111 shows `score1`, `en`=4'b1110 shows `score2`.
  - In GAME_OVER, the winner's digit is blanked (7'b1111111) while blink phase=1.
- Segment codes:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Any other value → 1111111.

## Timing
- Reset values:
  - Control: state IDLE, `run`=0, `ball_reset`=0, `serve_dir`=0, `winner`=00.
  - Counters: scores 0, all internal counters 0.
  - Display: `en`=4'b1111, `outs`=7'b1111111.
- Scanning starts on the first cycle after `resetb` goes high, with `score1`'s digit first.
- All outputs are registered.
- `point1`/`point2` at cycle n in RALLY:
  - Score, `serve_dir` and `winner` update at n+1.
  - State is POINT at n+1, with `ball_reset`=1 at n+1.
  - State is SERVE at n+2, unless GAME_OVER.
- `start_rise` sampled at cycle n: `ball_reset`=1 and state=SERVE at n+1.
- Serve length: RALLY is entered on the cycle after the SERVE_TICKS-th unpaused `tick`.
- A new score appears on `outs` within 2 cycles of the update.
- `resetb`=0 in any state aborts the match on the next edge and restores the reset values above.

## Structure
- Package `pp_pkg` holds: the state enum (3-bit), the segment-code constants, `SEG_BLANK`, and the `en` patterns `EN_P1`=0111 and `EN_P2`=1110.
- Sub-module `seg7_decode` is a combinational 4-bit → 7-bit decoder, instantiated once on the scan-mux output.

## Test plan
- Reset then `start_rise` → `ball_reset` pulses at n+1. After 8 ticks `run`=1; `outs` alternates 0000001/0000001 with `en` 0111/1110.
- `point2` pulse in RALLY → `score2`=1, `serve_dir`=1, one `ball_reset` pulse, `run`=0 for 8 ticks, then RALLY again.
- `point1` and `point2` in the same cycle → scores unchanged, state passes through POINT and back to SERVE.
- Nine `point1` pulses with WIN_SCORE=9 → `winner`=01. Digit 0111 alternates 0000100/1111111 every 4 ticks. A further `start_rise` → scores 0, `winner`=00, SERVE.
- `start`=0 for 20 ticks mid-SERVE → counter frozen and `run`=0. Points injected while paused are ignored; raising `start` does not restart the match.
- `resetb`=0 during RALLY with `score1`=5 → next edge: IDLE, scores 0, `en`=1111, `outs`=1111111.
